// File: rtl/piso_pkg.sv
// Shared types and limits for the parallel-in serial-out serializer.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } piso_state_t;

  localparam int PISO_MAX_WIDTH = 32;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module piso_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load_i,
  input  logic                       dec_i,
  output logic [$clog2(WIDTH)-1:0]   cnt_o,
  output logic                       zero_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_INIT;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// MSB-first serializer with valid/ready load and sof/eof frame markers.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             sof,
  output logic             eof
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > PISO_MAX_WIDTH) begin : g_width_check
    $error("piso_serializer: WIDTH out of range");
  end

  piso_state_t      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             load_acc;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  // Ready whenever the line is free or its last bit is showing, so frames can abut.
  assign load_ready = (state_q == IDLE) || eof_q;
  assign load_acc   = load_valid && load_ready;
  assign cnt_dec    = (state_q == SHIFT) && !load_acc;

  piso_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load_acc),
    .dec_i  (cnt_dec),
    .cnt_o  (cnt),
    .zero_o (cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    dout_d  = 1'b0;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    if (load_acc) begin
      // First bit goes straight to the output register; the rest wait in shreg.
      state_d = SHIFT;
      shreg_d = {din[WIDTH-2:0], 1'b0};
      dout_d  = din[WIDTH-1];
      valid_d = 1'b1;
      sof_d   = 1'b1;
`ifdef PISO_PARITY_EN
      par_d   = ^din;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (!cnt_zero) begin
            dout_d  = shreg_q[WIDTH-1];
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            valid_d = 1'b1;
`ifndef PISO_PARITY_EN
            eof_d   = (cnt == CW'(1));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
            dout_d  = par_q;
            valid_d = 1'b1;
            eof_d   = 1'b1;
`else
            state_d = IDLE;
`endif
          end
        end
        PARITY:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Randomized bench for piso_serializer against a frame-queue reference model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam bit PAR  = 1'b1;
`else
  localparam bit PAR  = 1'b0;
`endif
  localparam int FLEN = W + (PAR ? 1 : 0);

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         load_valid;
  logic         load_ready;
  logic         dout;
  logic         dout_valid;
  logic         sof;
  logic         eof;

  piso_serializer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .eof        (eof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { bit b; bit s; bit e; } fbit_t;

  fbit_t       pend_q[$];
  bit          m_v, m_d, m_s, m_e;
  int          n_chk, n_err;
  logic [63:0] rx_word, rx_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [W-1:0] d);
    if (PAR) return {55'd0, d, ^d};
    return {56'd0, d};
  endfunction

  task automatic model_clear();
    pend_q.delete();
    m_v = 0; m_d = 0; m_s = 0; m_e = 0;
  endtask

  // Model advance at a clock edge using the inputs that were stable before it.
  task automatic model_edge(input logic lv, input logic [W-1:0] d);
    fbit_t f;
    bit    ready;
    ready = !m_v || m_e;
    if (!rst_n) begin
      model_clear();
    end else if (lv && ready) begin
      pend_q.delete();
      for (int i = W - 1; i >= 0; i--) begin
        f.b = d[i];
        f.s = (i == W - 1);
        f.e = (!PAR && i == 0);
        pend_q.push_back(f);
      end
      if (PAR) begin
        f.b = ^d; f.s = 0; f.e = 1;
        pend_q.push_back(f);
      end
      f = pend_q.pop_front();
      m_v = 1; m_d = f.b; m_s = f.s; m_e = f.e;
    end else if (pend_q.size() > 0) begin
      f = pend_q.pop_front();
      m_v = 1; m_d = f.b; m_s = f.s; m_e = f.e;
    end else begin
      model_clear();
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".dout"},       64'(dout),       64'(m_d));
    chk({tag, ".dout_valid"}, 64'(dout_valid), 64'(m_v));
    chk({tag, ".sof"},        64'(sof),        64'(m_s));
    chk({tag, ".eof"},        64'(eof),        64'(m_e));
    chk({tag, ".load_ready"}, 64'(load_ready), 64'(!m_v || m_e));
  endtask

  task automatic step(input logic lv, input logic [W-1:0] d);
    load_valid = lv;
    din        = d;
    @(posedge clk);
    model_edge(lv, d);
    #1;
    compare_all("cyc");
    if (dout_valid) begin
      if (sof) rx_word = '0;
      rx_word = {rx_word[62:0], dout};
      if (eof) rx_last = rx_word;
    end
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    compare_all("rst_async");
    repeat (2) step(1'b1, W'($urandom));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rx_word = '0; rx_last = '0;
    model_clear();
    rst_n = 1'b0; load_valid = 1'b1; din = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    repeat (20) step(1'b0, '0);

    step(1'b1, 8'hA5);
    repeat (FLEN + 1) step(1'b0, '0);
    chk("frame_a5", rx_last, frame_of(8'hA5));

    step(1'b1, 8'hA5);
    repeat (FLEN) step(1'b1, 8'h3C);
    repeat (FLEN + 1) step(1'b0, '0);
    chk("frame_3c", rx_last, frame_of(8'h3C));

    step(1'b1, 8'h00);
    repeat (FLEN - 2) step(1'b1, 8'hFF);
    step(1'b0, 8'hFF);
    chk("busy_zero", rx_last, frame_of(8'h00));
    step(1'b1, 8'hFF);
    repeat (FLEN + 1) step(1'b0, '0);
    chk("frame_ff", rx_last, frame_of(8'hFF));

    step(1'b1, 8'hA5);
    step(1'b0, '0);
    step(1'b0, '0);
    mid_reset();
    step(1'b1, 8'h81);
    repeat (FLEN + 1) step(1'b0, '0);
    chk("frame_81", rx_last, frame_of(8'h81));

    step(1'b1, 8'h07);
    repeat (FLEN + 1) step(1'b0, '0);
    chk("frame_07", rx_last, frame_of(8'h07));

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) mid_reset();
      step(($urandom_range(0, 2) != 0), W'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
